// File: rtl/tb_ctrl_pkg.sv
// Shared definitions for the run sequencer: FSM state encoding and the
// completion status codes reported on o_status.
package tb_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] ST_NONE  = 2'd0;  // no run finished yet
    localparam logic [1:0] ST_DONE  = 2'd1;  // sample count reached
    localparam logic [1:0] ST_ABORT = 2'd2;  // host abort
    localparam logic [1:0] ST_EVENT = 2'd3;  // stopped on monitor event

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with zero flag, used for the fixed-length waits of
// the run sequencer (CLEAR hold time and DRAIN time).
//
// Ports:
//   clk      clock
//   reset    asynchronous active-low reset (counter -> 0)
//   i_load   load i_value (has priority over i_dec)
//   i_value  value to load
//   i_dec    decrement by one, stopping at zero
//   o_zero   counter currently holds zero
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_value;
        end else if (i_dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/run_sequencer.sv
// Run controller for the arithmetic testbench. A start command sequences one
// run: hold the chain in reset (CLEAR), enable the randomisers (RUN), let the
// DUT pipeline empty (DRAIN), then freeze the scoreboard and report (DONE).
//
// Ports:
//   clk              clock (same domain as the controlled chain)
//   reset            asynchronous active-low reset
//   i_start          single-cycle start request (IDLE/DONE only)
//   i_abort          abort request (CLEAR/RUN only)
//   i_sample_count   enabled cycles per run, 0 = free-run
//   i_drain_cycles   cycles to wait after enable drops
//   i_stop_on_event  end the run on the first monitor event
//   i_event          monitor event strobe
//   o_tb_reset       reset to randomisers/driver/monitor/scoreboard
//   o_enable         randomiser enable
//   o_freeze         scoreboard freeze
//   o_busy           run in progress (CLEAR, RUN, DRAIN)
//   o_done           run finished
//   o_status         0 none, 1 completed, 2 aborted, 3 stopped on event
//   o_sample_ctr     enabled cycles elapsed in the current/last run
module run_sequencer
    import tb_ctrl_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int CLEAR_CYCLES = 4,
    parameter int DRAIN_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [WIDTH-1:0]       i_sample_count,
    input  logic [DRAIN_WIDTH-1:0] i_drain_cycles,
    input  logic                   i_stop_on_event,
    input  logic                   i_event,
    output logic                   o_tb_reset,
    output logic                   o_enable,
    output logic                   o_freeze,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [1:0]             o_status,
    output logic [WIDTH-1:0]       o_sample_ctr
);

    // One timer serves both waits, so it must hold either load value.
    localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
    localparam int TW    = (CLR_W > DRAIN_WIDTH) ? CLR_W : DRAIN_WIDTH;
    localparam logic [TW-1:0] CLR_LOAD = TW'(CLEAR_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic [DRAIN_WIDTH-1:0] drain_q, drain_d;
    logic [WIDTH-1:0]       ctr_q, ctr_d;
    logic [1:0]             status_q, status_d;
    logic                   tb_reset_q, enable_q, freeze_q, busy_q, done_q;

    logic                   tmr_load, tmr_dec, tmr_zero;
    logic [TW-1:0]          tmr_val;
    logic [WIDTH-1:0]       ctr_inc;
    logic [DRAIN_WIDTH-1:0] drain_m1;
    logic                   count_hit;

    cycle_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_load  (tmr_load),
        .i_value (tmr_val),
        .i_dec   (tmr_dec),
        .o_zero  (tmr_zero)
    );

    // Timer counts down to zero and the wait ends on the cycle it reads zero,
    // so N wait cycles need a load of N-1. A drain of 0 still spends one
    // cycle in DRAIN, same as a drain of 1.
    assign drain_m1  = (drain_q == '0) ? '0 : drain_q - 1'b1;
    assign ctr_inc   = (ctr_q == '1) ? ctr_q : ctr_q + 1'b1;
    // ctr_inc is the count including the current RUN cycle.
    assign count_hit = (count_q != '0) && (ctr_inc == count_q);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        drain_d  = drain_q;
        ctr_d    = ctr_q;
        status_d = status_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_d  = S_CLEAR;
                    count_d  = i_sample_count;
                    drain_d  = i_drain_cycles;
                    ctr_d    = '0;
                    status_d = ST_NONE;
                    tmr_load = 1'b1;
                    tmr_val  = CLR_LOAD;
                end
            end
            S_CLEAR: begin
                if (i_abort) begin
                    state_d  = S_DONE;
                    status_d = ST_ABORT;
                end else if (tmr_zero) begin
                    state_d = S_RUN;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_RUN: begin
                ctr_d = ctr_inc;
                if (i_abort || (i_stop_on_event && i_event) || count_hit) begin
                    state_d  = S_DRAIN;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(drain_m1);
                    if (i_abort) begin
                        status_d = ST_ABORT;
                    end else if (i_stop_on_event && i_event) begin
                        status_d = ST_EVENT;
                    end else begin
                        status_d = ST_DONE;
                    end
                end
            end
            S_DRAIN: begin
                if (tmr_zero) begin
                    state_d = S_DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control outputs are decoded from the next state so they change on the
    // same edge as the state itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            drain_q    <= '0;
            ctr_q      <= '0;
            status_q   <= ST_NONE;
            tb_reset_q <= 1'b0;
            enable_q   <= 1'b0;
            freeze_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            drain_q    <= drain_d;
            ctr_q      <= ctr_d;
            status_q   <= status_d;
            tb_reset_q <= (state_d == S_CLEAR);
            enable_q   <= (state_d == S_RUN);
            freeze_q   <= (state_d == S_DONE);
            busy_q     <= (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_DRAIN);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign o_tb_reset   = tb_reset_q;
    assign o_enable     = enable_q;
    assign o_freeze     = freeze_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_status     = status_q;
    assign o_sample_ctr = ctr_q;

endmodule

// File: tb/tb_run_sequencer.sv
module tb_run_sequencer;

    localparam int WIDTH        = 32;
    localparam int CLEAR_CYCLES = 4;
    localparam int DRAIN_WIDTH  = 8;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   i_start = 1'b0;
    logic                   i_abort = 1'b0;
    logic [WIDTH-1:0]       i_sample_count = '0;
    logic [DRAIN_WIDTH-1:0] i_drain_cycles = '0;
    logic                   i_stop_on_event = 1'b0;
    logic                   i_event = 1'b0;
    logic                   o_tb_reset, o_enable, o_freeze, o_busy, o_done;
    logic [1:0]             o_status;
    logic [WIDTH-1:0]       o_sample_ctr;

    run_sequencer #(
        .WIDTH        (WIDTH),
        .CLEAR_CYCLES (CLEAR_CYCLES),
        .DRAIN_WIDTH  (DRAIN_WIDTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_start         (i_start),
        .i_abort         (i_abort),
        .i_sample_count  (i_sample_count),
        .i_drain_cycles  (i_drain_cycles),
        .i_stop_on_event (i_stop_on_event),
        .i_event         (i_event),
        .o_tb_reset      (o_tb_reset),
        .o_enable        (o_enable),
        .o_freeze        (o_freeze),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_status        (o_status),
        .o_sample_ctr    (o_sample_ctr)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- timeline model ----------------
    // A run is described by timestamps: the edge where start was taken, the
    // edge where the enabled phase ended, and the edge where DONE begins.
    // Cycle c is the clock period that ends at edge c.
    int     e       = 0;
    bit     running = 0;
    bit     fin     = 0;
    int     t_start = 0;
    int     t_exit  = -1;
    int     t_done  = 0;
    longint m_count = 0;
    int     m_drain = 0;
    longint m_ctr   = 0;
    longint k       = 0;
    logic [1:0] m_status = 2'd0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            e = 0; running = 0; fin = 0; t_start = 0; t_exit = -1; t_done = 0;
            m_count = 0; m_drain = 0; m_ctr = 0; m_status = 2'd0;
        end else begin
            e = e + 1;
            if (running) begin
                if (t_exit < 0) begin
                    if (e <= t_start + CLEAR_CYCLES) begin
                        if (i_abort) begin
                            running = 0; fin = 1; m_status = 2'd2;
                        end
                    end else begin
                        k = longint'(e - t_start - CLEAR_CYCLES);
                        m_ctr = (k > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : k;
                        if (i_abort || (i_stop_on_event && i_event) ||
                            (m_count != 0 && k == m_count)) begin
                            if (i_abort) m_status = 2'd2;
                            else if (i_stop_on_event && i_event) m_status = 2'd3;
                            else m_status = 2'd1;
                            t_exit = e;
                            t_done = e + ((m_drain == 0) ? 1 : m_drain);
                        end
                    end
                end else if (e == t_done) begin
                    running = 0; fin = 1;
                end
            end else if (i_start) begin
                running = 1; fin = 0; t_start = e; t_exit = -1;
                m_ctr = 0; m_status = 2'd0;
                m_count = longint'(i_sample_count);
                m_drain = int'(i_drain_cycles);
            end
        end
    end

    bit          chk_en = 0;
    logic [38:0] expv;
    bit          x_tbr, x_en;

    always @(negedge clk) begin
        if (chk_en) begin
            x_tbr = running && (t_exit < 0) && ((e + 1) <= t_start + CLEAR_CYCLES);
            x_en  = running && (t_exit < 0) && ((e + 1) >  t_start + CLEAR_CYCLES);
            expv  = {x_tbr, x_en, fin, running, fin, m_status, m_ctr[31:0]};
            check($sformatf("model cycle %0d {rst,en,frz,busy,done,st,ctr}", e + 1),
                  64'({o_tb_reset, o_enable, o_freeze, o_busy, o_done, o_status, o_sample_ctr}),
                  64'(expv));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic pulse_start(int cnt, int drn, bit stop);
        i_sample_count  = cnt[WIDTH-1:0];
        i_drain_cycles  = drn[DRAIN_WIDTH-1:0];
        i_stop_on_event = stop;
        i_start         = 1'b1;
        @(negedge clk);
        i_start         = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset outputs", 64'({o_tb_reset, o_enable, o_freeze, o_busy, o_done, o_status, o_sample_ctr}), 64'd0);
        reset  = 1'b1;
        chk_en = 1;
        @(negedge clk);

        // Test 1: nominal run, count 10, drain 3 (start edge = cycle 0).
        pulse_start(10, 3, 0);
        for (int c = 1; c <= 18; c++) begin
            check($sformatf("t1 tb_reset c%0d", c), 64'(o_tb_reset), 64'(c >= 1 && c <= 4));
            check($sformatf("t1 enable c%0d", c),   64'(o_enable),   64'(c >= 5 && c <= 14));
            check($sformatf("t1 done c%0d", c),     64'(o_done),     64'(c == 18));
            if (c < 18) @(negedge clk);
        end
        check("t1 sample_ctr", 64'(o_sample_ctr), 64'd10);
        check("t1 status", 64'(o_status), 64'd1);
        i_abort = 1'b1;                       // abort in DONE is ignored
        @(negedge clk);
        i_abort = 1'b0;
        check("t1 status after abort in DONE", 64'(o_status), 64'd1);

        // Test 2: free-run, ignored event (stop off), abort on 20th RUN cycle.
        pulse_start(0, 2, 0);
        repeat (9) @(negedge clk);            // cycle 10
        i_event = 1'b1;
        @(negedge clk);
        i_event = 1'b0;
        repeat (13) @(negedge clk);           // cycle 24 = 20th RUN cycle
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("t2 enable after abort", 64'(o_enable), 64'd0);
        check("t2 sample_ctr", 64'(o_sample_ctr), 64'd20);
        check("t2 status", 64'(o_status), 64'd2);
        check("t2 busy in drain", 64'(o_busy), 64'd1);
        repeat (3) @(negedge clk);
        check("t2 done", 64'(o_done), 64'd1);

        // Test 3: stop on event, event on 7th RUN cycle; an event in CLEAR is ignored.
        pulse_start(100, 0, 1);
        @(negedge clk);                       // cycle 2 (CLEAR)
        i_event = 1'b1;
        @(negedge clk);
        i_event = 1'b0;
        repeat (8) @(negedge clk);            // cycle 11 = 7th RUN cycle
        i_event = 1'b1;
        @(negedge clk);
        i_event = 1'b0;
        check("t3 sample_ctr", 64'(o_sample_ctr), 64'd7);
        check("t3 status", 64'(o_status), 64'd3);
        check("t3 enable", 64'(o_enable), 64'd0);
        @(negedge clk);
        check("t3 done after zero drain", 64'(o_done), 64'd1);

        // Test 4: abort, event and count expiry in the same cycle.
        pulse_start(5, 1, 1);
        repeat (8) @(negedge clk);            // cycle 9 = 5th RUN cycle
        i_abort = 1'b1;
        i_event = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        i_event = 1'b0;
        check("t4 status priority", 64'(o_status), 64'd2);
        check("t4 sample_ctr", 64'(o_sample_ctr), 64'd5);
        repeat (3) @(negedge clk);

        // Test 5: abort during CLEAR.
        pulse_start(10, 0, 0);
        @(negedge clk);                       // cycle 2
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("t5 done", 64'(o_done), 64'd1);
        check("t5 status", 64'(o_status), 64'd2);
        check("t5 sample_ctr", 64'(o_sample_ctr), 64'd0);
        check("t5 busy", 64'(o_busy), 64'd0);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("t5 enable stays low %0d", c), 64'(o_enable), 64'd0);
            @(negedge clk);
        end

        // Test 6: start during RUN ignored, reset mid-RUN, relaunch from DONE.
        pulse_start(50, 1, 0);
        repeat (9) @(negedge clk);            // cycle 10
        i_sample_count = 32'd3;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("t6 ctr after ignored start", 64'(o_sample_ctr), 64'd6);
        check("t6 still enabled", 64'(o_enable), 64'd1);
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1 check("t6 async reset outputs",
                 64'({o_tb_reset, o_enable, o_freeze, o_busy, o_done, o_status, o_sample_ctr}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        pulse_start(3, 1, 0);
        repeat (8) @(negedge clk);            // cycle 9
        check("t6 first run done", 64'(o_done), 64'd1);
        check("t6 first run ctr", 64'(o_sample_ctr), 64'd3);
        check("t6 first run status", 64'(o_status), 64'd1);
        pulse_start(2, 0, 0);                 // relaunch from DONE
        check("t6 relaunch ctr cleared", 64'(o_sample_ctr), 64'd0);
        check("t6 relaunch status cleared", 64'(o_status), 64'd0);
        check("t6 relaunch tb_reset", 64'(o_tb_reset), 64'd1);
        repeat (7) @(negedge clk);            // cycle 8
        check("t6 relaunch done", 64'(o_done), 64'd1);
        check("t6 relaunch ctr", 64'(o_sample_ctr), 64'd2);
        check("t6 relaunch status", 64'(o_status), 64'd1);

        repeat (2) @(negedge clk);
        chk_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
